sv_if_fifo: RTL and testbench

SV_IF_FIFO -- requirements
Module: sv_if_fifo

---
 rtl/sv_if_fifo.sv | 90 +++++++++
 tb/tb_sv_if_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sv_if_fifo.sv
// First-word-fall-through stream FIFO; a written word reaches m_data one cycle after its write edge.
// s_ready drops only when full, and offers refused while full are counted in a saturating ovf_count.
module sv_if_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    output logic                       s_afull,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 ovf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            ovf_q, ovf_d;
    logic                  afull_q, afull_d;
    logic                  wr_en, rd_en;

    // Handshake outputs come only from registered occupancy, never from the opposite side's inputs.
    assign s_ready   = (level_q < FULL_LVL);
    assign m_valid   = (level_q != '0);
    assign m_data    = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign ovf_count = ovf_q;
    assign s_afull   = afull_q;

    assign wr_en = s_valid && s_ready;
    assign rd_en = m_valid && m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (s_valid && !s_ready && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
        afull_d = (level_d >= AFULL_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            afull_q  <= afull_d;
        end
    end

    // Storage carries no reset; stale entries are never visible because m_valid gates them.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_sv_if_fifo.sv
// Bench for sv_if_fifo at DEPTH 4, 2 and 16: a queue-based model checked every cycle plus directed literal checks.
module tb_sv_if_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sv    [3];
    logic       mr    [3];
    logic [7:0] sd    [3];
    logic       srdy  [3];
    logic       afull [3];
    logic       mv    [3];
    logic [7:0] md    [3];
    logic [7:0] ovf   [3];
    logic [2:0] l0;
    logic [1:0] l1;
    logic [4:0] l2;

    int compared   = 0;
    int mismatched = 0;
    bit started    = 0;

    int         DEP [3] = '{4, 2, 16};
    int         TH  [3] = '{3, 1, 12};
    logic [7:0] q   [3][$];
    int         ovf_m   [3];
    bit         afull_m [3];
    logic [7:0] got [$];

    sv_if_fifo #(.DATA_WIDTH(8), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]),
        .s_afull(afull[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
        .level(l0), .ovf_count(ovf[0]));
    sv_if_fifo #(.DATA_WIDTH(8), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1]),
        .s_afull(afull[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
        .level(l1), .ovf_count(ovf[1]));
    sv_if_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12)) u2 (
        .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(srdy[2]), .s_data(sd[2]),
        .s_afull(afull[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
        .level(l2), .ovf_count(ovf[2]));

    function automatic int lvl(int i);
        case (i)
            0:       return int'(l0);
            1:       return int'(l1);
            default: return int'(l2);
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: occupancy is just the queue length; transfers follow the handshake rules.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
                ovf_m[i]   = 0;
                afull_m[i] = 1'b0;
            end else begin
                if (sv[i] && q[i].size() >= DEP[i] && ovf_m[i] < 255) ovf_m[i]++;
                if (sv[i] && q[i].size() < DEP[i]) begin
                    if (mr[i] && q[i].size() > 0) void'(q[i].pop_front());
                    q[i].push_back(sd[i]);
                end else if (mr[i] && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                end
                afull_m[i] = (q[i].size() >= TH[i]);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.level", i),   lvl(i),          q[i].size());
                chk($sformatf("u%0d.s_ready", i), int'(srdy[i]),   int'(q[i].size() < DEP[i]));
                chk($sformatf("u%0d.m_valid", i), int'(mv[i]),     int'(q[i].size() > 0));
                chk($sformatf("u%0d.s_afull", i), int'(afull[i]),  int'(afull_m[i]));
                chk($sformatf("u%0d.ovf", i),     int'(ovf[i]),    ovf_m[i]);
                if (q[i].size() > 0) chk($sformatf("u%0d.m_data", i), int'(md[i]), int'(q[i][0]));
            end
        end
    end

    initial begin
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; mr[i] = 1'b0; sd[i] = 8'h00;
        end
        cyc();
        cyc();
        started = 1'b1;
        rst = 1'b0;
        chk("reset_level", lvl(0), 0);
        chk("reset_s_ready", int'(srdy[0]), 1);
        chk("reset_m_valid", int'(mv[0]), 0);
        chk("reset_s_afull", int'(afull[0]), 0);
        chk("reset_ovf", int'(ovf[0]), 0);

        // Fill to full with the sink stalled.
        for (int k = 0; k < 4; k++) begin
            sv[0] = 1'b1; sd[0] = vals[k];
            cyc();
        end
        sv[0] = 1'b0;
        chk("full_level", lvl(0), 4);
        chk("full_s_ready", int'(srdy[0]), 0);
        chk("full_s_afull", int'(afull[0]), 1);
        chk("full_m_data", int'(md[0]), 'h11);

        // Offers while full are counted and dropped.
        sv[0] = 1'b1; sd[0] = 8'hEE;
        repeat (3) cyc();
        sv[0] = 1'b0;
        chk("ovf_after_3", int'(ovf[0]), 3);
        chk("ovf_level", lvl(0), 4);
        mr[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_vld%0d", k), int'(mv[0]), 1);
            chk($sformatf("drain_dat%0d", k), int'(md[0]), int'(vals[k]));
            cyc();
        end
        mr[0] = 1'b0;
        chk("drained_m_valid", int'(mv[0]), 0);

        // Full with simultaneous read: the write waits one cycle.
        for (int k = 0; k < 4; k++) begin
            sv[0] = 1'b1; sd[0] = vals[k];
            cyc();
        end
        sd[0] = 8'h55; mr[0] = 1'b1;
        cyc();
        chk("full_rw_level", lvl(0), 3);
        mr[0] = 1'b0;
        cyc();
        sv[0] = 1'b0;
        chk("full_rw_next_level", lvl(0), 4);
        chk("full_rw_ovf", int'(ovf[0]), 4);

        // Mid-operation reset with two words stored.
        mr[0] = 1'b1;
        cyc();
        cyc();
        mr[0] = 1'b0;
        chk("pre_rst_level", lvl(0), 2);
        rst = 1'b1; sv[0] = 1'b1; mr[0] = 1'b1; sd[0] = 8'h99;
        cyc();
        rst = 1'b0; sv[0] = 1'b0; mr[0] = 1'b0;
        chk("rst_level", lvl(0), 0);
        chk("rst_m_valid", int'(mv[0]), 0);
        chk("rst_ovf", int'(ovf[0]), 0);
        sv[0] = 1'b1; sd[0] = 8'hA5;
        cyc();
        sv[0] = 1'b0;
        chk("post_rst_m_valid", int'(mv[0]), 1);
        chk("post_rst_m_data", int'(md[0]), 'hA5);
        mr[0] = 1'b1;
        cyc();
        mr[0] = 1'b0;

        // Streaming 0..19 with both sides always ready.
        got.delete();
        mr[0] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            sv[0] = (k < 20);
            sd[0] = 8'(k);
            if (mv[0]) got.push_back(md[0]);
            chk("stream_level_le1", int'(lvl(0) <= 1), 1);
            cyc();
        end
        sv[0] = 1'b0; mr[0] = 1'b0;
        chk("stream_count", got.size(), 20);
        for (int k = 0; k < 20 && k < got.size(); k++) chk($sformatf("stream_word%0d", k), int'(got[k]), k);

        // Saturation of the overflow counter on the two-entry FIFO.
        sv[1] = 1'b1; sd[1] = 8'h3C;
        repeat (300) cyc();
        sv[1] = 1'b0;
        chk("ovf_saturate", int'(ovf[1]), 255);
        mr[1] = 1'b1;
        repeat (3) cyc();
        mr[1] = 1'b0;

        // Randomised traffic on all three depths.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (c < 1500) begin
                    sv[i] = ($urandom_range(0, 3) != 0);
                    mr[i] = ($urandom_range(0, 1) != 0);
                end else begin
                    sv[i] = ($urandom_range(0, 3) == 0);
                    mr[i] = ($urandom_range(0, 3) != 0);
                end
                sd[i] = 8'($urandom);
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; mr[i] = 1'b1;
        end
        repeat (20) cyc();
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d.final_empty", i), int'(mv[i]), 0);

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
